// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, counter width and state type shared by the UART TX and RX stages.
// Revision 1.0
`default_nettype none

package uart_pkg;
  localparam int CNT_W     = 11;
  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and parallel byte outputs of the UART receiver.
// Revision 1.0
`default_nettype none

interface uart_rx_if;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (input i_rx, output o_data, output o_valid, output o_frame_err, output o_busy);
  modport slave  (output i_rx, input o_data, input o_valid, input o_frame_err, input o_busy);
endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line; resets to the idle (high) level.
// Revision 1.0
`default_nettype none

module uart_rx_sync (
  input  wire logic i_clk,
  input  wire logic reset,
  input  wire logic i_async,
  output logic      o_sync
);
  logic meta;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      meta   <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end
endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-cycle valid / frame-error strobes.
// Option macro UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point. Revision 1.0
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input wire logic   i_clk,
  input wire logic   reset,
  uart_rx_if.master  rx_if
);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_s;
  logic sample_bit;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .reset   (reset),
    .i_async (rx_if.i_rx),
    .o_sync  (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rx_s from the previous edge, hist[1] from two edges back
  logic [1:0] hist;
  always_ff @(posedge i_clk) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end
  assign sample_bit = maj3({hist, rx_s});
`else
  assign sample_bit = rx_s;
`endif

  uart_state_e      state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [2:0]       bit_idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic [7:0]       data, data_nx;
  logic             valid, valid_nx;
  logic             frame_err, ferr_nx;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      bit_idx   <= idx_nx;
      shift     <= shift_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    idx_nx   = bit_idx;
    shift_nx = shift;
    data_nx  = data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        count_nx = '0;
        if (rx_s == START_LVL) state_nx = START;
      end
      START: begin
        if (count == HALF) begin
          count_nx = '0;
          idx_nx   = '0;
          // a start bit that is high again at mid-bit is a glitch: drop silently
          state_nx = (sample_bit == START_LVL) ? DATA : IDLE;
        end else begin
          count_nx = count + CNT_W'(1);
        end
      end
      DATA: begin
        if (count == LAST) begin
          count_nx          = '0;
          shift_nx[bit_idx] = sample_bit;
          if (bit_idx == LAST_IDX) state_nx = STOP;
          else                     idx_nx   = bit_idx + 3'd1;
        end else begin
          count_nx = count + CNT_W'(1);
        end
      end
      STOP: begin
        if (count == LAST) begin
          count_nx = '0;
          if (sample_bit == STOP_LVL) begin
            data_nx  = shift;
            valid_nx = 1'b1;
            state_nx = CLEANUP;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end else begin
          count_nx = count + CNT_W'(1);
        end
      end
      CLEANUP:   state_nx = IDLE;
      // hold off re-arming until the line returns to idle (break / stuck-low)
      WAIT_IDLE: if (rx_s == STOP_LVL) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_if.o_busy      = (state != IDLE);
    rx_if.o_data      = data;
    rx_if.o_valid     = valid;
    rx_if.o_frame_err = frame_err;
  end
endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives per-cycle serial line waveforms and checks strobes, data and busy
// against a timing-rule reference model of the receiver.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  typedef struct packed {
    int         at;
    bit         err;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk (clk),
    .reset (reset),
    .rx_if (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit         line[$];
  bit         exp_busy[];
  ev_t        exp_ev[$];
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_level(input bit v, input int n);
    for (int i = 0; i < n; i++) line.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] b, input bit stop);
    push_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) push_level(b[i], CPB);
    push_level(stop, CPB);
  endtask

  // Line level sampled by the DUT input flop at edge i; idle outside the waveform.
  function automatic bit lv(input int i);
    if (i < 0 || i >= line.size()) return 1'b1;
    return line[i];
  endfunction

  // Value the receiver decides on at sample edge e (synchronizer adds two edges).
  function automatic bit samp(input int e);
`ifdef UART_RX_MAJORITY_EN
    int s;
    s = int'(lv(e - 2)) + int'(lv(e - 3)) + int'(lv(e - 4));
    return (s >= 2);
`else
    return lv(e - 2);
`endif
  endfunction

  function automatic void mark(input int a, input int b);
    for (int i = a; i <= b; i++)
      if (i >= 0 && i < exp_busy.size()) exp_busy[i] = 1'b1;
  endfunction

  // Walks the waveform with the frame timing rules: x is an edge at which the
  // receiver is idle and looks at the synchronized line.
  task automatic model();
    int n, x, sv, s, y;
    logic [7:0] b, good;
    n = line.size();
    exp_busy = new[n];
    exp_ev.delete();
    good = exp_data;
    x = 0;
    while (x < n) begin
      if (lv(x - 2)) begin
        x++;
      end else begin
        sv = x + 1 + HALF;
        if (samp(sv)) begin
          mark(x, sv - 1);
          x = sv + 1;
        end else begin
          b = 8'h00;
          for (int k = 0; k < 8; k++) b[k] = samp(sv + (k + 1) * CPB);
          s = sv + 9 * CPB;
          if (samp(s)) begin
            good = b;
            exp_ev.push_back('{s, 1'b0, good});
            mark(x, s);
            x = s + 2;
          end else begin
            exp_ev.push_back('{s, 1'b1, good});
            y = s + 1;
            while (!lv(y - 2)) y++;
            mark(x, y - 1);
            x = y + 1;
          end
        end
      end
    end
    exp_data = good;
  endtask

  // Must be entered at a negedge; plays the waveform one level per clock.
  task automatic run_phase(input string name);
    ev_t obs[$];
    int  n, busy_bad, both;
    model();
    n = line.size();
    busy_bad = 0;
    both = 0;
    bus.i_rx = line[0];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.o_valid || bus.o_frame_err) obs.push_back('{k, bus.o_frame_err, bus.o_data});
      if (bus.o_valid && bus.o_frame_err) both++;
      if (bus.o_busy !== exp_busy[k]) busy_bad++;
      bus.i_rx = (k + 1 < n) ? line[k + 1] : 1'b1;
    end
    check({name, " strobe count"}, obs.size(), exp_ev.size());
    for (int i = 0; i < obs.size() && i < exp_ev.size(); i++) begin
      check({name, " strobe cycle"}, obs[i].at, exp_ev[i].at);
      check({name, " strobe kind"}, 32'(obs[i].err), 32'(exp_ev[i].err));
      check({name, " strobe data"}, 32'(obs[i].d), 32'(exp_ev[i].d));
    end
    check({name, " busy cycles wrong"}, busy_bad, 0);
    check({name, " valid+err together"}, both, 0);
    check({name, " held data"}, 32'(bus.o_data), 32'(exp_data));
    line.delete();
  endtask

  initial begin
    int p, cut, strobes;
    logic [7:0] b;
    bit stop;
    bus.i_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data", 32'(bus.o_data), 0);
    check("reset valid", 32'(bus.o_valid), 0);
    check("reset frame_err", 32'(bus.o_frame_err), 0);
    check("reset busy", 32'(bus.o_busy), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    push_level(1'b1, 4); push_frame(8'hA5, 1'b1); push_level(1'b1, 40);
    run_phase("a5");

    push_level(1'b1, 4); push_level(1'b0, 3); push_level(1'b1, 30);
    run_phase("glitch_start");

    push_level(1'b1, 4);
    push_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) push_level(b_of(8'h3C, i), CPB);
    push_level(1'b0, CPB + 40);
    push_level(1'b1, 20); push_frame(8'h11, 1'b1); push_level(1'b1, 40);
    run_phase("frame_err");

    push_level(1'b1, 4);
    push_frame(8'h00, 1'b1); push_frame(8'hFF, 1'b1); push_frame(8'h80, 1'b1);
    push_level(1'b1, 40);
    run_phase("back2back");

    // reset in the middle of data bit 4 of 0x5A
    push_level(1'b1, 4); push_frame(8'h5A, 1'b1);
    cut = 4 + 5 * CPB + CPB / 2;
    strobes = 0;
    bus.i_rx = line[0];
    for (int k = 0; k < cut; k++) begin
      @(negedge clk);
      if (bus.o_valid || bus.o_frame_err) strobes++;
      bus.i_rx = line[k + 1];
    end
    line.delete();
    check("pre-reset busy", 32'(bus.o_busy), 1);
    reset = 1'b1;
    bus.i_rx = 1'b1;
    @(negedge clk);
    check("midreset data", 32'(bus.o_data), 0);
    check("midreset valid", 32'(bus.o_valid), 0);
    check("midreset frame_err", 32'(bus.o_frame_err), 0);
    check("midreset busy", 32'(bus.o_busy), 0);
    check("midreset strobes", strobes, 0);
    reset = 1'b0;
    exp_data = 8'h00;
    repeat (3) @(negedge clk);
    push_level(1'b1, 4); push_frame(8'hC3, 1'b1); push_level(1'b1, 40);
    run_phase("after_reset");

    // one-cycle high pulse seen by the receiver exactly at data bit 4's sample edge
    p = 4;
    push_level(1'b1, p); push_frame(8'h00, 1'b1); push_level(1'b1, 40);
    line[p + 1 + HALF + 5 * CPB] = 1'b1;
    run_phase("glitch_data");
`ifdef UART_RX_MAJORITY_EN
    check("glitch_data byte", 32'(bus.o_data), 32'h00);
`else
    check("glitch_data byte", 32'(bus.o_data), 32'h10);
`endif

    for (int r = 0; r < 3; r++) begin
      push_level(1'b1, 4);
      for (int f = 0; f < 6; f++) begin
        b = 8'($urandom_range(255));
        stop = ($urandom_range(7) != 0);
        p = line.size();
        push_frame(b, stop);
        push_level(1'b1, $urandom_range(2 * CPB));
        if ($urandom_range(3) == 0) begin
          cut = p + $urandom_range(10 * CPB - 1);
          line[cut] = !line[cut];
        end
      end
      push_level(1'b1, 200);
      run_phase("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic bit b_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction
endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver for the USB-Blaster verification environment: it samples the serial line driven by the UART transmitter and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) into parallel bytes. It sits directly downstream of the TX stage, either in loopback benches or on the FPGA RX pin. Each good byte is presented with a one-cycle valid strobe, and bad stop bits are flagged.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per bit. Legal range is 4..2047 (11-bit counter).
- i_clk, in, 1: sole clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- i_rx, in, 1: asynchronous serial line. Idle level is high.
- o_data, out, 8: last good byte received. Holds its value between frames.
- o_valid, out, 1: one-cycle pulse; o_data is new and valid in this cycle.
- o_frame_err, out, 1: one-cycle pulse; the stop bit sampled low and the byte was dropped.
- o_busy, out, 1: high in every state except IDLE.

## Operation
- i_rx passes through a 2-flop synchronizer (rx_s) before any use. Both flops reset to 1.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- Reset values: all outputs are 0, state is IDLE, counter and bit index are 0, shift register is 0.
- **IDLE:** when rx_s==0, go to START with count=0. Otherwise stay.
- **START:** count increments until count==HALF, where the bit is sampled.
  - Sample 0: go to DATA with count=0 and bit index=0.
  - Sample 1: go back to IDLE. The glitch is rejected and no flag is raised.
- **DATA:** count increments to CLKS_PER_BIT-1, then the bit is sampled into shift[bit index] and count resets to 0.
  - After index 7, go to STOP. Otherwise the index increments.
- **STOP:** count to CLKS_PER_BIT-1, then sample.
  - Sample 1: o_data←shift, o_valid=1, go to CLEANUP.
  - Sample 0: o_frame_err=1, o_data unchanged, go to WAIT_IDLE.
- **CLEANUP:** one cycle, then IDLE.
- **WAIT_IDLE:** stay until rx_s==1, then IDLE. This prevents a break condition or stuck-low line from re-triggering reception.
- o_valid and o_frame_err are never both high. Neither can be high in two consecutive cycles.
- There is no backpressure. The consumer must take o_data in the o_valid cycle or read it before the next o_valid.
- Reset asserted mid-frame aborts the frame on the next edge with no strobe.
- Unused state encodings go to IDLE.

## Timing
- Let E0 be the first clock edge at which i_rx is sampled low.
  - IDLE detects the start bit at E2.
  - Start validation occurs at E(3+HALF).
  - Data bit k (k=0..7) is sampled at E(3+HALF+(k+1)·CLKS_PER_BIT).
  - Stop bit is sampled at E(3+HALF+9·CLKS_PER_BIT).
- o_valid and o_frame_err are high in the cycle after the stop sample edge.
- Example with CLKS_PER_BIT=16: HALF=7 and the strobe follows E154.
- Earliest re-arm is 2 cycles after the stop sample (CLEANUP, then IDLE). This allows back-to-back frames with a single stop bit and up to ~HALF cycles of transmitter drift.
- o_busy rises at E2 (cycle after) and falls on entry to IDLE.

## Configuration
- Macro UART_RX_MAJORITY_EN.
- **Defined:** every sample point (start validation, data, stop) takes the 2-of-3 majority of rx_s at the sample edge and the two preceding edges. Sample-point timing is unchanged. A single-cycle glitch at a sample point is filtered.
- **Undefined:** a single sample of rx_s at the sample edge. The 3-sample history register is not built.

## Structure
- Package uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP, CLEANUP, WAIT_IDLE);
  - the counter-width localparam (11);
  - the frame constants (8 data bits, start level 0, stop level 1).
- The package is shared with the TX stage.
- One sub-module, uart_rx_sync: the 2-flop synchronizer with reset value 1.

## Test plan
- Loopback from uart_tx (CLKS_PER_BIT=16) sending 0xA5 → one o_valid pulse after E154, o_data=0xA5, o_frame_err never high.
- 3-cycle low pulse on idle i_rx → START is abandoned at E10, state returns to IDLE, no strobes, o_busy low again.
- Frame 0x3C with stop bit forced 0 and the line held low 40 cycles → o_frame_err pulse, o_data keeps its prior value, state stays in WAIT_IDLE until the line goes high, then the next frame 0x11 gives o_valid with o_data=0x11.
- Back-to-back 0x00, 0xFF, 0x80 with 1 stop bit each → three o_valid pulses with exactly those values.
- reset asserted during data bit 4 of 0x5A → all outputs 0 on the next edge, no strobe. After release, 0xC3 is received correctly.
- One-cycle high glitch on a 0 data bit exactly at its sample edge (byte 0x00):
  - Macro undefined → byte received as 0x10 (bit 4 set).
  - Macro defined → byte received as 0x00.
